// File: rtl/fp_sp_to_dp_widen_pkg.sv
// Shared FPU constants and the widening converter's state encoding.
package fp_sp_to_dp_widen_pkg;

  // Rounding-mode codes (shared by the FPU conversion blocks)
  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RZ  = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;

  localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
  localparam logic [63:0] QNAN_DP = 64'h7FF8_0000_0000_0000;

  localparam int unsigned SP_BIAS   = 127;
  localparam int unsigned DP_BIAS   = 1023;
  localparam int unsigned BIAS_DIFF = 896;

  // Exponent loaded for a subnormal before the first normalisation shift
  localparam logic [10:0] SUB_E_INIT = 11'(BIAS_DIFF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp_sp_classify.sv
// Combinational classification of a single-precision word; reusable across FPU blocks.
module fp_sp_classify (
  input  logic [31:0] sp,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_snan,
  output logic        is_subnormal
);

  logic exp_zero;
  logic exp_ones;
  logic man_zero;

  // Field decode and class flags
  always_comb begin
    exp_zero     = (sp[30:23] == '0);
    exp_ones     = (sp[30:23] == '1);
    man_zero     = (sp[22:0] == '0);
    is_zero      = exp_zero & man_zero;
    is_subnormal = exp_zero & ~man_zero;
    is_inf       = exp_ones & man_zero;
    is_nan       = exp_ones & ~man_zero;
    is_snan      = exp_ones & ~man_zero & ~sp[22];
  end

endmodule

// File: rtl/fp_sp_to_dp_widen.sv
// Multi-cycle SP->DP widening converter with iterative subnormal normalisation.
module fp_sp_to_dp_widen
  import fp_sp_to_dp_widen_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = 1,
  parameter int unsigned TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_sp,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_dp,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_invalid
);

  state_t      state, state_nx;
  logic [23:0] m, m_nx;
  logic [10:0] e, e_nx;
  logic        sign_q;
  logic        accept;
  logic [63:0] imm_dp;

  logic is_zero, is_inf, is_nan, is_snan, is_subnormal;

  fp_sp_classify u_classify (
    .sp           (in_sp),
    .is_zero      (is_zero),
    .is_inf       (is_inf),
    .is_nan       (is_nan),
    .is_snan      (is_snan),
    .is_subnormal (is_subnormal)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready & ~flush;

  // Single-cycle result for non-subnormal operands
  always_comb begin
    imm_dp = {in_sp[31], 11'({3'b000, in_sp[30:23]} + 11'(BIAS_DIFF)), in_sp[22:0], 29'h0};
    if (is_nan)       imm_dp = QNAN_DP;
    else if (is_inf)  imm_dp = {in_sp[31], 11'h7FF, 52'h0};
    else if (is_zero) imm_dp = {in_sp[31], 63'h0};
  end

  // One normalisation step: coarse shift when the top SHIFT_STEP bits are clear,
  // otherwise single-bit steps so the leading one never overshoots bit 23
  always_comb begin
    m_nx = m << 1;
    e_nx = e - 11'd1;
    if (m[23 -: SHIFT_STEP] == '0) begin
      m_nx = m << SHIFT_STEP;
      e_nx = e - 11'(SHIFT_STEP);
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = is_subnormal ? NORM : DONE;
      NORM:    if (m_nx[23]) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Operand capture, normalisation registers and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m           <= '0;
      e           <= '0;
      sign_q      <= 1'b0;
      out_dp      <= '0;
      out_tag     <= '0;
      out_invalid <= 1'b0;
    end else if (accept) begin
      out_tag     <= in_tag;
      sign_q      <= in_sp[31];
      m           <= {1'b0, in_sp[22:0]};
      e           <= SUB_E_INIT;
      out_dp      <= imm_dp;
      out_invalid <= is_snan;
    end else if (state == NORM && !flush) begin
      m <= m_nx;
      e <= e_nx;
      if (m_nx[23]) out_dp <= {sign_q, e_nx, m_nx[22:0], 29'h0};
    end
  end

endmodule
